// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the RV32I instruction encoder.
// The slave side is the encoder. The master side is whoever issues requests and observes the writes.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_class;
    logic [3:0]  req_alu_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        flush;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_pulse;
    logic        err_flag;
    logic [15:0] count;

    modport slave (
        input  req_valid, req_class, req_alu_op, req_rd, req_rs1, req_rs2, req_imm, flush,
        output req_ready, imem_we, imem_addr, imem_wdata, err_pulse, err_flag, count
    );

    modport master (
        output req_valid, req_class, req_alu_op, req_rd, req_rs1, req_rs2, req_imm, flush,
        input  req_ready, imem_we, imem_addr, imem_wdata, err_pulse, err_flag, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes R/I/LOAD/STORE/BRANCH requests into RV32I words.
// Each accepted word is written to sequential instruction-memory addresses, one word every two cycles.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t      r_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_count;
    logic        r_err_pulse;
    logic        r_err_flag;

    logic signed [31:0] w_imm;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_br_f3;
    logic        w_shift;
    logic        w_imm12_ok;
    logic        w_shamt_ok;
    logic        w_br_imm_ok;
    logic        w_legal;
    logic [31:0] w_word;

    assign w_imm       = bus.req_imm;
    assign w_imm12_ok  = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
    assign w_shamt_ok  = (w_imm >= 32'sd0) && (w_imm <= 32'sd31);
    assign w_br_imm_ok = !w_imm[0] && (w_imm >= -32'sd4096) && (w_imm <= 32'sd4094);
    assign w_shift     = (bus.req_alu_op == 4'b0101) || (bus.req_alu_op == 4'b0110) ||
                         (bus.req_alu_op == 4'b0111);
    assign w_f7        = ((bus.req_alu_op == 4'b0001) || (bus.req_alu_op == 4'b0111)) ?
                         7'b0100000 : 7'b0000000;

    always_comb begin
        w_f3 = 3'b000;
        case (bus.req_alu_op)
            4'b0000, 4'b0001: w_f3 = 3'b000;
            4'b0101:          w_f3 = 3'b001;
            4'b1000:          w_f3 = 3'b010;
            4'b1001:          w_f3 = 3'b011;
            4'b0100:          w_f3 = 3'b100;
            4'b0110, 4'b0111: w_f3 = 3'b101;
            4'b0011:          w_f3 = 3'b110;
            4'b0010:          w_f3 = 3'b111;
            default:          w_f3 = 3'b000;
        endcase
    end

    always_comb begin
        w_br_f3 = 3'b000;
        case (bus.req_alu_op)
            4'b1010: w_br_f3 = 3'b000;
            4'b1011: w_br_f3 = 3'b001;
            4'b1100: w_br_f3 = 3'b100;
            4'b1101: w_br_f3 = 3'b101;
            4'b1110: w_br_f3 = 3'b110;
            4'b1111: w_br_f3 = 3'b111;
            default: w_br_f3 = 3'b000;
        endcase
    end

    always_comb begin
        w_legal = 1'b0;
        w_word  = '0;
        case (bus.req_class)
            3'd0: begin
                w_legal = (bus.req_alu_op <= 4'b1001);
                w_word  = {w_f7, bus.req_rs2, bus.req_rs1, w_f3, bus.req_rd, 7'b0110011};
            end
            3'd1: begin
                w_legal = (bus.req_alu_op != 4'b0001) && (bus.req_alu_op <= 4'b1001) &&
                          (w_shift ? w_shamt_ok : w_imm12_ok);
                if (w_shift)
                    w_word = {w_f7, w_imm[4:0], bus.req_rs1, w_f3, bus.req_rd, 7'b0010011};
                else
                    w_word = {w_imm[11:0], bus.req_rs1, w_f3, bus.req_rd, 7'b0010011};
            end
            3'd2: begin
                w_legal = (bus.req_alu_op == 4'b0000) && w_imm12_ok;
                w_word  = {w_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, 7'b0000011};
            end
            3'd3: begin
                w_legal = (bus.req_alu_op == 4'b0000) && w_imm12_ok;
                w_word  = {w_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, w_imm[4:0], 7'b0100011};
            end
            3'd4: begin
                w_legal = (bus.req_alu_op >= 4'b1010) && w_br_imm_ok;
                w_word  = {w_imm[12], w_imm[10:5], bus.req_rs2, bus.req_rs1, w_br_f3,
                           w_imm[4:1], w_imm[11], 7'b1100011};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = '0;
            end
        endcase
    end

    // The count already includes the word being written during its strobe cycle.
    // The address advances only once the strobe ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_count     <= '0;
            r_err_pulse <= 1'b0;
            r_err_flag  <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bus.flush) begin
                r_state    <= IDLE;
                r_we       <= 1'b0;
                r_addr     <= BASE_ADDR;
                r_count    <= '0;
                r_err_flag <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.req_valid) begin
                            if (w_legal) begin
                                r_state <= WRITE;
                                r_we    <= 1'b1;
                                r_wdata <= w_word;
                                r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
                            end else begin
                                r_err_pulse <= 1'b1;
                                r_err_flag  <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                        r_addr  <= r_addr + 32'd4;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_we    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A flush raised during the strobe cycle has to cancel that same strobe.
    // For this reason the write enable is gated by flush combinationally.
    assign bus.imem_we    = r_we & ~bus.flush;
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.count      = r_count;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_flag   = r_err_flag;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder.
// u_dut0 uses the default base address and u_dut1 starts at the top of the address space.
module tb_instr_encoder;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    instr_encoder_if if0 ();
    instr_encoder_if if1 ();

    instr_encoder u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        if0.req_class  = c;
        if0.req_alu_op = op;
        if0.req_rd     = rd;
        if0.req_rs1    = rs1;
        if0.req_rs2    = rs2;
        if0.req_imm    = imm;
        if0.req_valid  = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        if0.req_valid = 1'b0; if0.req_class = '0; if0.req_alu_op = '0; if0.req_rd = '0;
        if0.req_rs1 = '0; if0.req_rs2 = '0; if0.req_imm = '0; if0.flush = 1'b0;
        if1.req_valid = 1'b0; if1.req_class = '0; if1.req_alu_op = '0; if1.req_rd = '0;
        if1.req_rs1 = '0; if1.req_rs2 = '0; if1.req_imm = '0; if1.flush = 1'b0;

        #3;
        chk("rst_we",    {31'd0, if0.imem_we},   32'd0);
        chk("rst_addr",  if0.imem_addr,          32'd0);
        chk("rst_wdata", if0.imem_wdata,         32'd0);
        chk("rst_count", {16'd0, if0.count},     32'd0);
        chk("rst_err",   {30'd0, if0.err_pulse, if0.err_flag}, 32'd0);
        chk("rst_addr1", if1.imem_addr,          32'hFFFF_FFFC);
        step();
        rst = 1'b0;
        chk("rst_ready", {31'd0, if0.req_ready}, 32'd1);

        // addi x1,x0,5
        drive(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        if0.req_valid = 1'b0;
        chk("addi_we",    {31'd0, if0.imem_we},   32'd1);
        chk("addi_addr",  if0.imem_addr,          32'h0);
        chk("addi_wdata", if0.imem_wdata,         32'h0050_0093);
        chk("addi_count", {16'd0, if0.count},     32'd1);
        chk("addi_ready", {31'd0, if0.req_ready}, 32'd0);
        step();
        chk("addi_we_off", {31'd0, if0.imem_we},  32'd0);
        chk("addi_adv",    if0.imem_addr,         32'h4);
        chk("wdata_hold",  if0.imem_wdata,        32'h0050_0093);

        if0.flush = 1'b1;
        step();
        if0.flush = 1'b0;
        chk("flush_addr",  if0.imem_addr,         32'h0);
        chk("flush_count", {16'd0, if0.count},    32'd0);

        // sub x3,x1,x2 then sw x2,8(x1) held valid through the stall
        drive(3'd0, 4'b0001, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        chk("sub_we",    {31'd0, if0.imem_we},   32'd1);
        chk("sub_wdata", if0.imem_wdata,         32'h4020_81B3);
        chk("sub_addr",  if0.imem_addr,          32'h0);
        drive(3'd3, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd8);
        step();
        chk("stall_we",    {31'd0, if0.imem_we},   32'd0);
        chk("stall_ready", {31'd0, if0.req_ready}, 32'd1);
        chk("stall_wdata", if0.imem_wdata,         32'h4020_81B3);
        step();
        if0.req_valid = 1'b0;
        chk("sw_we",    {31'd0, if0.imem_we}, 32'd1);
        chk("sw_wdata", if0.imem_wdata,       32'h0020_A423);
        chk("sw_addr",  if0.imem_addr,        32'h4);
        chk("sw_count", {16'd0, if0.count},   32'd2);
        step();

        // beq x1,x2,-4
        drive(3'd4, 4'b1010, 5'd0, 5'd1, 5'd2, -32'sd4);
        step();
        if0.req_valid = 1'b0;
        chk("beq_wdata", if0.imem_wdata, 32'hFE20_8EE3);
        chk("beq_addr",  if0.imem_addr,  32'h8);
        step();

        // Illegal: addi imm 2048, then a branch with an odd offset
        drive(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd2048);
        step();
        if0.req_valid = 1'b0;
        chk("e1_we",    {31'd0, if0.imem_we},   32'd0);
        chk("e1_pulse", {31'd0, if0.err_pulse}, 32'd1);
        chk("e1_flag",  {31'd0, if0.err_flag},  32'd1);
        chk("e1_addr",  if0.imem_addr,          32'hC);
        chk("e1_count", {16'd0, if0.count},     32'd3);
        chk("e1_ready", {31'd0, if0.req_ready}, 32'd1);
        step();
        chk("e1_pulse_end", {31'd0, if0.err_pulse}, 32'd0);
        drive(3'd4, 4'b1010, 5'd0, 5'd1, 5'd2, 32'd3);
        step();
        if0.req_valid = 1'b0;
        chk("e2_pulse", {31'd0, if0.err_pulse}, 32'd1);
        chk("e2_we",    {31'd0, if0.imem_we},   32'd0);
        chk("e2_addr",  if0.imem_addr,          32'hC);
        step();
        drive(3'd5, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd0);
        step();
        if0.req_valid = 1'b0;
        chk("e3_pulse", {31'd0, if0.err_pulse}, 32'd1);
        chk("e3_count", {16'd0, if0.count},     32'd3);

        // srai x5,x6,31
        drive(3'd1, 4'b0111, 5'd5, 5'd6, 5'd0, 32'd31);
        step();
        if0.req_valid = 1'b0;
        chk("srai_wdata", if0.imem_wdata, 32'h41F3_5293);
        chk("srai_addr",  if0.imem_addr,  32'hC);
        step();
        // lw x7,-4(x2)
        drive(3'd2, 4'b0000, 5'd7, 5'd2, 5'd0, -32'sd4);
        step();
        if0.req_valid = 1'b0;
        chk("lw_wdata", if0.imem_wdata,     32'hFFC1_2383);
        chk("lw_addr",  if0.imem_addr,      32'h10);
        chk("lw_count", {16'd0, if0.count}, 32'd5);
        step();

        // A legal handshake that coincides with a flush must be discarded
        drive(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1);
        if0.flush = 1'b1;
        step();
        if0.req_valid = 1'b0;
        if0.flush = 1'b0;
        chk("fh_we",    {31'd0, if0.imem_we},  32'd0);
        chk("fh_count", {16'd0, if0.count},    32'd0);
        chk("fh_flag",  {31'd0, if0.err_flag}, 32'd0);
        chk("fh_addr",  if0.imem_addr,         32'h0);

        // Flush raised during the WRITE cycle
        drive(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd1);
        step();
        if0.req_valid = 1'b0;
        chk("fw_we_pre", {31'd0, if0.imem_we}, 32'd1);
        if0.flush = 1'b1;
        #1;
        chk("fw_we_gated", {31'd0, if0.imem_we}, 32'd0);
        step();
        if0.flush = 1'b0;
        chk("fw_addr",  if0.imem_addr,          32'h0);
        chk("fw_count", {16'd0, if0.count},     32'd0);
        chk("fw_ready", {31'd0, if0.req_ready}, 32'd1);

        // Wrapping base address on the second instance
        if1.req_class = 3'd1; if1.req_alu_op = 4'b0000; if1.req_rd = 5'd1; if1.req_imm = 32'd5;
        if1.req_valid = 1'b1;
        step();
        chk("w1_we",   {31'd0, if1.imem_we}, 32'd1);
        chk("w1_addr", if1.imem_addr,        32'hFFFF_FFFC);
        step();
        step();
        if1.req_valid = 1'b0;
        chk("w2_we",    {31'd0, if1.imem_we}, 32'd1);
        chk("w2_addr",  if1.imem_addr,        32'h0);
        chk("w2_count", {16'd0, if1.count},   32'd2);
        step();

        // Reset in the middle of a write, with err_flag already set
        drive(3'd7, 4'b0000, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        drive(3'd1, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        if0.req_valid = 1'b0;
        chk("rw_we_pre", {31'd0, if0.imem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_we",    {31'd0, if0.imem_we},   32'd0);
        chk("rw_addr",  if0.imem_addr,          32'h0);
        chk("rw_count", {16'd0, if0.count},     32'd0);
        chk("rw_wdata", if0.imem_wdata,         32'h0);
        chk("rw_flag",  {31'd0, if0.err_flag},  32'd0);
        chk("rw_ready", {31'd0, if0.req_ready}, 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("rw_after", if0.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
